// File: rtl/seq_pattern_tx_if.sv
// Handshake and serial-stream bundle between a pattern requester and seq_pattern_tx.
// The master side requests runs; the slave side (the transmitter) drives the stream.
interface seq_pattern_tx_if #(
    parameter int WIDTH = 5,
    parameter int CNT_W = 4
);
    logic             start;
    logic             abort;
    logic             use_def;
    logic [WIDTH-1:0] pattern_in;
    logic [CNT_W-1:0] repeat_n;
    logic             x;
    logic             valid;
    logic             busy;
    logic             done;

    modport master (
        output start, abort, use_def, pattern_in, repeat_n,
        input  x, valid, busy, done
    );

    modport slave (
        input  start, abort, use_def, pattern_in, repeat_n,
        output x, valid, busy, done
    );
endinterface

// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: latches a pattern and repeat count on start, then
// streams the pattern MSB-first, copies back-to-back, with a done pulse at the end.
module seq_pattern_tx #(
    parameter int               WIDTH   = 5,
    parameter int               CNT_W   = 4,
    parameter logic [WIDTH-1:0] DEF_PAT = WIDTH'(5'b10011)
) (
    input  logic                  clk,
    input  logic                  reset,
    seq_pattern_tx_if.slave       bus
);
    localparam int IDX_W = $clog2(WIDTH);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t           state_q,   state_d;
    logic [WIDTH-1:0] pat_q,     pat_d;
    logic [CNT_W-1:0] reps_q,    reps_d;
    logic [IDX_W-1:0] bit_idx_q, bit_idx_d;
    logic             x_q,       x_d;
    logic             valid_q,   valid_d;
    logic             busy_q,    busy_d;
    logic             done_q,    done_d;

    logic [WIDTH-1:0] sel_pat_s;
    logic [IDX_W-1:0] next_idx_s;

    // State and output registers; reset clears the stream immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            pat_q     <= '0;
            reps_q    <= '0;
            bit_idx_q <= '0;
            x_q       <= 1'b0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pat_q     <= pat_d;
            reps_q    <= reps_d;
            bit_idx_q <= bit_idx_d;
            x_q       <= x_d;
            valid_q   <= valid_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign sel_pat_s  = bus.use_def ? DEF_PAT : bus.pattern_in;
    assign next_idx_s = bit_idx_q - IDX_W'(1);

    // Next-state logic; bit_idx_q holds the index of the bit currently on x.
    always_comb begin
        state_d   = state_q;
        pat_d     = pat_q;
        reps_d    = reps_q;
        bit_idx_d = bit_idx_q;
        x_d       = x_q;
        valid_d   = valid_q;
        busy_d    = busy_q;
        done_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.start && !bus.abort) begin
                    pat_d     = sel_pat_s;
                    reps_d    = (bus.repeat_n == CNT_W'(0)) ? CNT_W'(1) : bus.repeat_n;
                    bit_idx_d = IDX_W'(WIDTH - 1);
                    x_d       = sel_pat_s[WIDTH-1];
                    valid_d   = 1'b1;
                    busy_d    = 1'b1;
                    state_d   = SEND;
                end else begin
                    x_d     = 1'b0;
                    valid_d = 1'b0;
                    busy_d  = 1'b0;
                end
            end
            SEND: begin
                if (bus.abort) begin
                    x_d     = 1'b0;
                    valid_d = 1'b0;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else if (bit_idx_q != IDX_W'(0)) begin
                    bit_idx_d = next_idx_s;
                    x_d       = pat_q[next_idx_s];
                end else if (reps_q > CNT_W'(1)) begin
                    // Wrap straight into the next copy so there is no idle bit between copies.
                    reps_d    = reps_q - CNT_W'(1);
                    bit_idx_d = IDX_W'(WIDTH - 1);
                    x_d       = pat_q[WIDTH-1];
                end else begin
                    x_d     = 1'b0;
                    valid_d = 1'b0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                x_d     = 1'b0;
                valid_d = 1'b0;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    assign bus.x     = x_q;
    assign bus.valid = valid_q;
    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
endmodule

// File: tb/tb_seq_pattern_tx.sv
// Self-checking bench for seq_pattern_tx: directed scenarios plus randomized runs
// checked against a bit-queue reference built from pattern and repeat count.
module tb_seq_pattern_tx;
    localparam int WIDTH = 5;
    localparam int CNT_W = 4;
    localparam logic [WIDTH-1:0] DEF = 5'b10011;

    logic clk;
    logic reset;
    int   tests;
    int   fails;

    seq_pattern_tx_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

    seq_pattern_tx #(.WIDTH(WIDTH), .CNT_W(CNT_W), .DEF_PAT(DEF)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag, input logic exp_done);
        chk({tag, ".x"},     {31'd0, bus.x},     32'd0);
        chk({tag, ".valid"}, {31'd0, bus.valid}, 32'd0);
        chk({tag, ".busy"},  {31'd0, bus.busy},  32'd0);
        chk({tag, ".done"},  {31'd0, bus.done},  {31'd0, exp_done});
    endtask

    task automatic idle_cycle(input string tag);
        @(posedge clk); #1;
        chk_idle(tag, 1'b0);
    endtask

    // Reference stream: every copy is the full pattern, MSB first.
    task automatic build_stream(input logic [WIDTH-1:0] p, input int reps, output bit q[$]);
        q = {};
        for (int r = 0; r < reps; r++)
            for (int i = WIDTH - 1; i >= 0; i--)
                q.push_back(p[i]);
    endtask

    // Starts a run (called at posedge+1) and checks each streamed cycle.
    task automatic run(input string tag, input bit ud, input logic [WIDTH-1:0] pin,
                       input logic [CNT_W-1:0] rn, input int abort_at, input int restart_at);
        bit q[$];
        logic [WIDTH-1:0] p;
        int eff;
        p   = ud ? DEF : pin;
        eff = (rn == 0) ? 1 : int'(rn);
        build_stream(p, eff, q);
        bus.use_def = ud; bus.pattern_in = pin; bus.repeat_n = rn;
        bus.start = 1'b1; bus.abort = 1'b0;
        @(posedge clk); #1;
        for (int k = 0; k < q.size(); k++) begin
            bus.start = 1'b0;
            chk($sformatf("%s.x[%0d]", tag, k), {31'd0, bus.x}, {31'd0, q[k]});
            chk($sformatf("%s.v[%0d]", tag, k), {30'd0, bus.valid, bus.busy}, 32'd3);
            chk($sformatf("%s.d[%0d]", tag, k), {31'd0, bus.done}, 32'd0);
            // Inputs wander mid-run; the latched pattern must not follow them.
            bus.pattern_in = WIDTH'($urandom);
            bus.repeat_n   = CNT_W'($urandom);
            bus.use_def    = 1'($urandom);
            if (k == restart_at) bus.start = 1'b1;
            if (k == abort_at) begin
                bus.abort = 1'b1;
                @(posedge clk); #1;
                bus.abort = 1'b0;
                bus.start = 1'b0;
                chk_idle({tag, ".abort"}, 1'b0);
                return;
            end
            @(posedge clk); #1;
        end
        bus.start = 1'b0;
        chk_idle({tag, ".end"}, 1'b1);
    endtask

    initial begin
        tests = 0; fails = 0;
        reset = 1'b1;
        bus.start = 1'b0; bus.abort = 1'b0; bus.use_def = 1'b0;
        bus.pattern_in = '0; bus.repeat_n = '0;
        repeat (2) @(posedge clk);
        #1;
        chk_idle("reset", 1'b0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;

        // Single default copy, then two copies back-to-back with start during done.
        run("t1", 1'b1, 5'b00000, 4'd1, -1, -1);
        run("t2", 1'b1, 5'b00000, 4'd2, -1, -1);
        idle_cycle("t2.after");

        run("t3", 1'b0, 5'b10101, 4'd0, -1, -1);
        idle_cycle("t3.after");

        run("t4", 1'b1, 5'b00000, 4'd1, -1, 2);
        idle_cycle("t4.after");

        run("t5", 1'b1, 5'b00000, 4'd3, 1, -1);
        idle_cycle("t5.after");
        run("t5b", 1'b1, 5'b00000, 4'd1, -1, -1);
        idle_cycle("t5b.after");

        // abort together with start in IDLE: nothing starts.
        bus.start = 1'b1; bus.abort = 1'b1; bus.use_def = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0; bus.abort = 1'b0;
        chk_idle("abort_start", 1'b0);
        idle_cycle("abort_start2");

        // Maximum repeat count with a user pattern.
        run("maxrep", 1'b0, 5'b01110, 4'd15, -1, -1);
        idle_cycle("maxrep.after");

        // Reset raised between edges mid-run clears outputs before the next edge.
        bus.use_def = 1'b1; bus.repeat_n = 4'd3; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk_idle("async_rst", 1'b0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        repeat (3) idle_cycle("post_rst");

        // Randomized runs with occasional abort or ignored restart.
        for (int n = 0; n < 25; n++) begin
            int ab, rs;
            ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 9)) : -1;
            rs = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 9)) : -1;
            run($sformatf("rnd%0d", n), 1'($urandom), WIDTH'($urandom),
                CNT_W'($urandom_range(0, 4)), ab, rs);
            if ($urandom_range(0, 1) == 1) idle_cycle($sformatf("rnd%0d.gap", n));
        end
        idle_cycle("final");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
